// File: rtl/ndn_rx_framer.sv
// Receive-side framer for the NDN router: parses chip-select-delimited SPI frames into
// metadata/length/name-prefix fields and buffers the payload in a small valid/ready FIFO.
module ndn_rx_framer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PREFIX_BYTES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_cs_n,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_valid,
  output logic [PREFIX_BYTES*8-1:0] prefix_out,
  output logic [5:0]                length_out,
  output logic [7:0]                metadata_out,
  output logic                      interest_packet,
  output logic                      prefix_ready,
  output logic [7:0]                pay_data,
  output logic                      pay_valid,
  input  logic                      pay_ready,
  output logic                      frame_done,
  output logic                      frame_error,
  output logic                      busy
);

  localparam int PW = PREFIX_BYTES * 8;
  localparam int SW = PW - 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [5:0] PFX_LAST = 6'(PREFIX_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, META, LEN, PREFIX, PAYLOAD, TAIL, ERR
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      meta_q, meta_d;
  logic [5:0]      len_q, len_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [SW-1:0]   shadow_q, shadow_d;
  logic [PW-1:0]   prefix_out_q, prefix_out_d;
  logic [5:0]      length_out_q, length_out_d;
  logic [7:0]      metadata_out_q, metadata_out_d;
  logic            prefix_ready_q, prefix_ready_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_error_q, frame_error_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push;
  logic            pop;
  logic            full;
  logic            last_pay;

  assign pay_valid = (count_q != '0);
  assign pop       = pay_valid & pay_ready;
  assign full      = (count_q == FULL_CNT);
  assign last_pay  = (({1'b0, cnt_q} + 7'd1) == {1'b0, len_q});

  // NOTE: every variable gets a default first so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    state_d        = state_q;
    meta_d         = meta_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    prefix_out_d   = prefix_out_q;
    length_out_d   = length_out_q;
    metadata_out_d = metadata_out_q;
    prefix_ready_d = 1'b0;
    frame_done_d   = 1'b0;
    frame_error_d  = 1'b0;
    push           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!frame_cs_n) begin
          state_d = META;
          if (rx_valid) begin
            meta_d  = rx_byte;
            state_d = LEN;
          end
        end
      end
      META: begin
        if (frame_cs_n) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (rx_valid) begin
          meta_d  = rx_byte;
          state_d = LEN;
        end
      end
      LEN: begin
        if (frame_cs_n) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (rx_valid) begin
          if (rx_byte[7:6] != 2'b00) begin
            frame_error_d = 1'b1;
            state_d       = ERR;
          end else begin
            len_d   = rx_byte[5:0];
            cnt_d   = '0;
            state_d = PREFIX;
          end
        end
      end
      PREFIX: begin
        if (frame_cs_n) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (rx_valid) begin
          shadow_d = SW'({shadow_q, rx_byte});
          cnt_d    = cnt_q + 6'd1;
          // Final prefix byte goes straight to the output register, bypassing the shadow.
          if (cnt_q == PFX_LAST) begin
            prefix_out_d   = {shadow_q, rx_byte};
            length_out_d   = len_q;
            metadata_out_d = meta_q;
            prefix_ready_d = 1'b1;
            cnt_d          = '0;
            if (len_q == '0) begin
              frame_done_d = 1'b1;
              state_d      = TAIL;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        if (frame_cs_n) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else if (rx_valid) begin
          // A full FIFO can still take the byte if the consumer pops in the same cycle.
          if (full && !pop) begin
            frame_error_d = 1'b1;
            state_d       = ERR;
          end else begin
            push = 1'b1;
            if (last_pay) begin
              frame_done_d = 1'b1;
              state_d      = TAIL;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
      end
      TAIL, ERR: begin
        if (frame_cs_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      meta_q         <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      shadow_q       <= '0;
      prefix_out_q   <= '0;
      length_out_q   <= '0;
      metadata_out_q <= '0;
      prefix_ready_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      meta_q         <= meta_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      prefix_out_q   <= prefix_out_d;
      length_out_q   <= length_out_d;
      metadata_out_q <= metadata_out_d;
      prefix_ready_q <= prefix_ready_d;
      frame_done_q   <= frame_done_d;
      frame_error_q  <= frame_error_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // NOTE: payload storage is not reset; pay_data is gated by pay_valid so stale
  // entries never reach the port.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte;
  end

  assign pay_data        = pay_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign prefix_out      = prefix_out_q;
  assign length_out      = length_out_q;
  assign metadata_out    = metadata_out_q;
  assign interest_packet = metadata_out_q[7];
  assign prefix_ready    = prefix_ready_q;
  assign frame_done      = frame_done_q;
  assign frame_error     = frame_error_q;
  assign busy            = (state_q != IDLE);

endmodule
